// File: rtl/ppc_uop_sequencer.sv
// Fetch-to-decode sequencer: cracks PowerPC update-form loads/stores and lmw/stmw into simple uops
// behind a registered valid/ready output stage.
module ppc_uop_sequencer #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter bit MW_EN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [0:INSTR_WIDTH-1] in_instr,
  input  logic [0:PC_WIDTH-1]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:INSTR_WIDTH-1] out_instr,
  output logic [0:PC_WIDTH-1]   out_pc,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, UPD2, MULTI} state_t;

  state_t      state_reg;
  logic [0:5]  base_reg;
  logic [0:4]  cur_rt_reg;
  logic [0:4]  ra_reg;
  logic [0:15] disp_reg;

  logic [0:5]  opcd;
  logic [0:4]  rt;
  logic [0:4]  ra;
  logic [0:15] d;
  logic        is_upd_op;
  logic        is_upd_store;
  logic        is_upd;
  logic        is_mw;
  logic        accept;
  logic        load_slot;

  assign opcd = in_instr[0:5];
  assign rt   = in_instr[6:10];
  assign ra   = in_instr[11:15];
  assign d    = in_instr[16:31];

  assign is_upd_op    = opcd inside {6'd33, 6'd35, 6'd37, 6'd39, 6'd41, 6'd43, 6'd45};
  assign is_upd_store = opcd inside {6'd37, 6'd39, 6'd45};
  // Loads that would overwrite their own base (RA==RT) are invalid forms and pass through untouched.
  assign is_upd = is_upd_op && (ra != 5'd0) && (is_upd_store || (ra != rt));
  assign is_mw  = MW_EN && ((opcd == 6'd46) || (opcd == 6'd47));

  assign load_slot = ~out_valid | out_ready;
  assign in_ready  = ~flush & (state_reg == IDLE) & load_slot;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      out_last   <= 1'b0;
      base_reg   <= '0;
      cur_rt_reg <= '0;
      ra_reg     <= '0;
      disp_reg   <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load_slot) begin
      case (state_reg)
        UPD2: begin
          // Second half of an update form: addi RA,RA,D writes back the effective address.
          out_instr <= {6'd14, ra_reg, ra_reg, disp_reg};
          out_last  <= 1'b1;
          state_reg <= IDLE;
        end
        MULTI: begin
          out_instr  <= {base_reg, cur_rt_reg, ra_reg, disp_reg};
          out_last   <= (cur_rt_reg == 5'd31);
          cur_rt_reg <= cur_rt_reg + 5'd1;
          disp_reg   <= disp_reg + 16'd4;
          if (cur_rt_reg == 5'd31) state_reg <= IDLE;
        end
        default: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            ra_reg    <= ra;
            if (is_upd) begin
              out_instr <= {opcd[0:4], 1'b0, rt, ra, d};
              out_last  <= 1'b0;
              disp_reg  <= d;
              state_reg <= UPD2;
            end else if (is_mw) begin
              base_reg   <= (opcd == 6'd46) ? 6'd32 : 6'd36;
              out_instr  <= {((opcd == 6'd46) ? 6'd32 : 6'd36), rt, ra, d};
              cur_rt_reg <= rt + 5'd1;
              disp_reg   <= d + 16'd4;
              out_last   <= (rt == 5'd31);
              state_reg  <= (rt == 5'd31) ? IDLE : MULTI;
            end else begin
              out_instr <= in_instr;
              out_last  <= 1'b1;
              state_reg <= IDLE;
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppc_uop_sequencer.sv
// Bench for ppc_uop_sequencer: directed vector table, multi-cycle corner cases, and a random run
// checked against a queue-of-pending-uops reference model.
module tb_ppc_uop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [0:31] in_instr = '0;
  logic [0:31] in_pc = '0;

  logic        in_ready, out_valid, out_last, busy;
  logic [0:31] out_instr, out_pc;
  logic        in_ready1, out_valid1, out_last1, busy1;
  logic [0:31] out_instr1, out_pc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ppc_uop_sequencer #(.PC_WIDTH(32), .INSTR_WIDTH(32), .MW_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_last(out_last), .busy(busy)
  );

  ppc_uop_sequencer #(.PC_WIDTH(32), .INSTR_WIDTH(32), .MW_EN(1'b0)) u_dut_nomw (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1), .out_pc(out_pc1),
    .out_last(out_last1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] instr;
    int          n;
    logic [31:0] u0;
    logic [31:0] ul;
  } vec_t;

  typedef struct {
    logic [31:0] i;
    logic [31:0] pc;
    logic        l;
  } uop_t;

  vec_t vecs[11];
  uop_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference expansion computed straight from the ISA rules.
  function automatic void expand(input logic [31:0] ins, input logic [31:0] pc);
    logic [5:0]  op;
    logic [4:0]  rt, ra;
    logic [15:0] dd;
    bit          upd_load, upd_store;
    op = ins[31:26]; rt = ins[25:21]; ra = ins[20:16]; dd = ins[15:0];
    upd_load  = (op == 33) || (op == 35) || (op == 41) || (op == 43);
    upd_store = (op == 37) || (op == 39) || (op == 45);
    if ((upd_load || upd_store) && ra != 0 && (upd_store || ra != rt)) begin
      q.push_back('{{op - 6'd1, rt, ra, dd}, pc, 1'b0});
      q.push_back('{{6'd14, ra, ra, dd}, pc, 1'b1});
    end else if (op == 46 || op == 47) begin
      for (int r = int'(rt); r <= 31; r++) begin
        logic [4:0]  r5;
        logic [15:0] disp;
        r5   = 5'(r);
        disp = dd + 16'(4 * (r - int'(rt)));
        q.push_back('{{((op == 46) ? 6'd32 : 6'd36), r5, ra, disp}, pc, (r == 31)});
      end
    end else begin
      q.push_back('{ins, pc, 1'b1});
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [12];
    logic [31:0] ins;
    ops = '{6'd31, 6'd33, 6'd35, 6'd37, 6'd39, 6'd41, 6'd43, 6'd45, 6'd46, 6'd47, 6'd14, 6'd58};
    ins = $urandom;
    ins[31:26] = ops[$urandom_range(0, 11)];
    case ($urandom_range(0, 7))
      0: ins[20:16] = 5'd0;
      1, 2: ins[20:16] = ins[25:21];
      3: ins[25:21] = 5'(28 + $urandom_range(0, 3));
      default: ;
    endcase
    return ins;
  endfunction

  task automatic run_vec(input int idx);
    int          n, nl;
    logic [31:0] first, lastu, pc;
    logic        lastflag;
    vec_t        v;
    v = vecs[idx];
    pc = 32'h1000 + 32'(idx * 4);
    in_instr = v.instr; in_pc = pc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("vec_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    n = 0; nl = 0; first = '0; lastu = '0; lastflag = 1'b0;
    while (out_valid && n < 40) begin
      n++;
      if (n == 1) first = out_instr;
      lastu = out_instr;
      lastflag = out_last;
      if (out_last) nl++;
      chk("vec_pc", out_pc, pc);
      chk("vec_busy", busy, (n != v.n));
      tick();
      #1;
    end
    chk("vec_count", n, v.n);
    chk("vec_first", first, v.u0);
    chk("vec_final", lastu, v.ul);
    chk("vec_lastflag", lastflag, 1);
    chk("vec_one_last", nl, 1);
    chk("vec_drained", out_valid, 0);
    $display("[TB] vec %0d instr 0x%08h -> %0d uops, first 0x%08h final 0x%08h", idx, v.instr, n, first, lastu);
  endtask

  task automatic flush_seq(input bit use_rst);
    in_instr = 32'hBB830000; in_pc = 32'h2000; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("fl_uop0", out_instr, 32'h83830000);
    tick();
    #1;
    chk("fl_uop1", out_instr, 32'h83A30004);
    chk("fl_busy_before", busy, 1);
    if (use_rst) rst_n = 1'b0; else flush = 1'b1;
    in_instr = 32'h7C642A14; in_valid = 1'b1;
    #1;
    if (!use_rst) chk("fl_in_ready_blocked", in_ready, 0);
    tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_out_last", out_last, 0);
    chk("fl_in_ready", in_ready, 1);
    if (use_rst) begin
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc", out_pc, 0);
    end
    tick();
    #1;
    chk("fl_stays_empty", out_valid, 0);
    $display("[TB] %s on 2nd uop of lmw r28 done", use_rst ? "reset" : "flush");
  endtask

  initial begin
    int acc_cnt;
    vecs[0]  = '{32'h7C642A14, 1,  32'h7C642A14, 32'h7C642A14};
    vecs[1]  = '{32'h94A1FFF8, 2,  32'h90A1FFF8, 32'h3821FFF8};
    vecs[2]  = '{32'hBBA37FFC, 3,  32'h83A37FFC, 32'h83E38004};
    vecs[3]  = '{32'hBFE10000, 1,  32'h93E10000, 32'h93E10000};
    vecs[4]  = '{32'h84820004, 2,  32'h80820004, 32'h38420004};
    vecs[5]  = '{32'h84800004, 1,  32'h84800004, 32'h84800004};
    vecs[6]  = '{32'h84840004, 1,  32'h84840004, 32'h84840004};
    vecs[7]  = '{32'h94840004, 2,  32'h90840004, 32'h38840004};
    vecs[8]  = '{32'hB8010000, 32, 32'h80010000, 32'h83E1007C};
    vecs[9]  = '{32'hE8820005, 1,  32'hE8820005, 32'hE8820005};
    vecs[10] = '{32'hBBC3FFFC, 2,  32'h83C3FFFC, 32'h83E30000};

    repeat (2) tick();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i);

    // Back-pressure on an update-form load.
    in_instr = 32'h84820004; in_pc = 32'h3000; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("bp_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_instr", out_instr, 32'h80820004);
      chk("bp_hold_last", out_last, 0);
      chk("bp_in_ready_low", in_ready, 0);
      tick();
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_instr", out_instr, 32'h80820004);
    tick();
    #1;
    chk("bp_uop1", out_instr, 32'h38420004);
    chk("bp_uop1_last", out_last, 1);
    tick();
    #1;
    chk("bp_drained", out_valid, 0);
    $display("[TB] back-pressure lwzu r4,4(r2) done");

    // lmw with expansion disabled passes through as one uop.
    in_instr = 32'hBBA37FFC; in_pc = 32'h4000; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tick();
    in_valid = 1'b0;
    #1;
    chk("nomw_instr", out_instr1, 32'hBBA37FFC);
    chk("nomw_last", out_last1, 1);
    chk("nomw_busy", busy1, 0);
    chk("mw_uop0", out_instr, 32'h83A37FFC);
    tick();
    #1;
    chk("nomw_drained", out_valid1, 0);
    repeat (3) tick();
    $display("[TB] MW_EN=0 lmw pass-through done");

    flush_seq(1'b0);
    flush_seq(1'b1);

    // Random traffic against the queue model.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    acc_cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit exp_ir, acc;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      #1;
      exp_ir = !flush && (q.size() <= 1) && (q.size() == 0 || out_ready);
      chk("rnd_in_ready", in_ready, exp_ir);
      chk("rnd_out_valid", out_valid, (q.size() > 0));
      chk("rnd_busy", busy, (q.size() > 1));
      if (q.size() > 0) begin
        chk("rnd_instr", out_instr, q[0].i);
        chk("rnd_pc", out_pc, q[0].pc);
        chk("rnd_last", out_last, q[0].l);
      end
      acc = in_valid && exp_ir;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          expand(in_instr, in_pc);
          acc_cnt++;
          $display("[TB] rnd cyc %0d accept 0x%08h pc 0x%08h, %0d uops pending", cyc, in_instr, in_pc, q.size());
        end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
    $display("[TB] random phase accepted %0d instructions", acc_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
